// File: rtl/key_sequence_player_pkg.sv
// Shared definitions for the keypad replay block: FSM state type and key-line constants.
package key_sequence_player_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_FINISH
  } ksp_state_t;

  localparam logic [9:0] KEY_NONE = '0;
  localparam logic [3:0] BCD_MAX  = 4'd9;

endpackage

// File: rtl/key_sequence_player_bcd_to_onehot.sv
// BCD digit to one-hot key line; the inverse of the keypad encoder. Non-BCD values give no key.
module bcd_to_onehot
  import key_sequence_player_pkg::*;
(
  input  logic [3:0] digit,
  output logic [9:0] onehot
);

  always_comb begin
    onehot = KEY_NONE;
    if (digit <= BCD_MAX) onehot = 10'd1 << digit;
  end

endmodule

// File: rtl/key_sequence_player.sv
// Replays an 8-digit BCD code as timed one-hot key press/release pulses on x_out.
// Optional KSP_ABORT_EN adds the abort input and aborted pulse output.
module key_sequence_player
  import key_sequence_player_pkg::*;
#(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned PRESS_CYC = 5,
  parameter int unsigned GAP_CYC   = 5,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   code_in,
  output logic [9:0]            x_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            digit_idx
`ifdef KSP_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  aborted
`endif
);

  localparam int unsigned CODE_W = 4 * DIGITS;

  ksp_state_t          state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [CODE_W-1:0]   shreg_q, shreg_d;
  logic [9:0]          x_d;
  logic                busy_d, done_d, err_d;
  logic [2:0]          idx_d;
  logic                code_bad;
  logic                abort_req;
  logic [3:0]          digit_sel;
  logic [9:0]          key_next;

`ifdef KSP_ABORT_EN
  logic aborted_d;
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    code_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (code_in[4*i +: 4] > BCD_MAX) code_bad = 1'b1;
  end

  // The first digit goes straight from code_in; the shift register holds the remaining
  // digits pre-shifted so the next one to press is always in the top nibble.
  assign digit_sel = (state_q == S_IDLE) ? code_in[CODE_W-1 -: 4] : shreg_q[CODE_W-1 -: 4];

  bcd_to_onehot u_dec (
    .digit  (digit_sel),
    .onehot (key_next)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    shreg_d = shreg_q;
    x_d     = x_out;
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = 1'b0;
    idx_d   = digit_idx;
`ifdef KSP_ABORT_EN
    aborted_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        idx_d  = '0;
        x_d    = KEY_NONE;
        busy_d = 1'b0;
        if (start && !abort_req) begin
          if (code_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = S_PRESS;
            timer_d = '0;
            shreg_d = code_in << 4;
            x_d     = key_next;
            busy_d  = 1'b1;
          end
        end
      end
      S_PRESS: begin
        if (timer_q == CNT_W'(PRESS_CYC - 1)) begin
          state_d = S_GAP;
          timer_d = '0;
          x_d     = KEY_NONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_GAP: begin
        if (timer_q == CNT_W'(GAP_CYC - 1)) begin
          timer_d = '0;
          if (digit_idx == 3'(DIGITS - 1)) begin
            state_d = S_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_PRESS;
            idx_d   = digit_idx + 3'd1;
            shreg_d = shreg_q << 4;
            x_d     = key_next;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_req && (state_q == S_PRESS || state_q == S_GAP)) begin
      state_d = S_IDLE;
      timer_d = '0;
      x_d     = KEY_NONE;
      busy_d  = 1'b0;
      idx_d   = '0;
`ifdef KSP_ABORT_EN
      aborted_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      shreg_q   <= '0;
      x_out     <= KEY_NONE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      digit_idx <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      shreg_q   <= shreg_d;
      x_out     <= x_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      digit_idx <= idx_d;
    end
  end

`ifdef KSP_ABORT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aborted <= 1'b0;
    else        aborted <= aborted_d;
  end
`endif

endmodule
